// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write integer register file with a per-register
// scoreboard (busy bits), same-cycle write-to-read bypass, a selectable
// reset image and a committed-write counter.
//
// Interface timing: there is no valid/ready handshake on this block.
// Reads are purely combinational. A write is a single-cycle command that
// commits at the posedge on which wr_en is sampled high. An issue is a
// single-cycle command that marks issue_reg busy at that same posedge.
// ID drives the read and issue ports; WB drives the write port.
module regfile_sb #(
   parameter int WORD_LEN   = 32,
   parameter int ADDR_LEN   = 5,
   parameter int RESET_MODE = 1,
   parameter int CNT_LEN    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_LEN-1:0] rd_addr1,
   input  logic [ADDR_LEN-1:0] rd_addr2,
   output logic [WORD_LEN-1:0] rd_data1,
   output logic [WORD_LEN-1:0] rd_data2,
   output logic                hazard1,
   output logic                hazard2,
   input  logic                issue_en,
   input  logic [ADDR_LEN-1:0] issue_reg,
   input  logic                wr_en,
   input  logic [ADDR_LEN-1:0] wr_addr,
   input  logic [WORD_LEN-1:0] wr_data,
   output logic                busy_any,
   output logic [CNT_LEN-1:0]  wr_count
);

   localparam int DEPTH = 2 ** ADDR_LEN;

   logic [WORD_LEN-1:0] mem [DEPTH];
   logic [DEPTH-1:0]    busy_q;
   logic [DEPTH-1:0]    busy_d;
   logic [CNT_LEN-1:0]  wr_count_q;
   logic                wr_commit;
   logic                byp1;
   logic                byp2;

   // Reset image of register idx: either all zero or the register's own index.
   function automatic logic [WORD_LEN-1:0] reset_word(input int idx);
      if (RESET_MODE == 1) begin
         return WORD_LEN'(idx);
      end
      return '0;
   endfunction

   // Writes to register 0 are discarded and never counted.
   assign wr_commit = wr_en && (wr_addr != '0);

   // A write-back in flight to the addressed register supplies the read data.
   assign byp1 = wr_en && (wr_addr == rd_addr1);
   assign byp2 = wr_en && (wr_addr == rd_addr2);

   // Register array: reset image on reset, otherwise commit the write-back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= reset_word(i);
         end
      end else if (wr_commit) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port 1: register 0 reads zero, then bypass, then stored value.
   always_comb begin
      rd_data1 = '0;
      if (rd_addr1 != '0) begin
         if (byp1) begin
            rd_data1 = wr_data;
         end else begin
            rd_data1 = mem[rd_addr1];
         end
      end
   end

   // Read port 2: register 0 reads zero, then bypass, then stored value.
   always_comb begin
      rd_data2 = '0;
      if (rd_addr2 != '0) begin
         if (byp2) begin
            rd_data2 = wr_data;
         end else begin
            rd_data2 = mem[rd_addr2];
         end
      end
   end

   // Next scoreboard state: issue sets (and beats a same-cycle write-back,
   // since a newer writer is now pending), write-back clears, else hold.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < DEPTH; r++) begin
         if (issue_en && (issue_reg == ADDR_LEN'(r))) begin
            busy_d[r] = 1'b1;
         end else if (wr_en && (wr_addr == ADDR_LEN'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Scoreboard register: all pending writers are forgotten on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Committed-write counter, wrapping modulo 2**CNT_LEN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count_q <= '0;
      end else if (wr_commit) begin
         wr_count_q <= wr_count_q + CNT_LEN'(1);
      end
   end

   // A same-cycle write-back resolves the hazard; this cycle's issue does not
   // show until the busy bit is registered.
   assign hazard1  = busy_q[rd_addr1] && !byp1;
   assign hazard2  = busy_q[rd_addr2] && !byp2;
   assign busy_any = |busy_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb. Stimulus drives the inputs one
// time unit after each posedge and queues the values each output must show
// in that cycle; a monitor samples the DUT on every negedge and retires the
// queued expectations. A second instance with a 4-bit counter shares all
// inputs so the counter wrap can be observed alongside the default width.
module tb_regfile_sb;

   localparam int W = 32;

   // Output selectors used by the scoreboard.
   localparam int S_RD1  = 0;
   localparam int S_RD2  = 1;
   localparam int S_HZ1  = 2;
   localparam int S_HZ2  = 3;
   localparam int S_BUSY = 4;
   localparam int S_CNT  = 5;
   localparam int S_CNT4 = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b1;
   logic reset;
   always #5 clk = ~clk;

   logic [4:0]  rd_addr1, rd_addr2, issue_reg, wr_addr;
   logic [31:0] rd_data1, rd_data2, wr_data;
   logic [31:0] rd_data1_b, rd_data2_b;
   logic        hazard1, hazard2, issue_en, wr_en, busy_any;
   logic        hazard1_b, hazard2_b, busy_any_b;
   logic [15:0] wr_count;
   logic [3:0]  wr_count4;

   regfile_sb #(.WORD_LEN(32), .ADDR_LEN(5), .RESET_MODE(1), .CNT_LEN(16)) dut (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .hazard1(hazard1), .hazard2(hazard2),
      .issue_en(issue_en), .issue_reg(issue_reg),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_any(busy_any), .wr_count(wr_count)
   );

   regfile_sb #(.WORD_LEN(32), .ADDR_LEN(5), .RESET_MODE(1), .CNT_LEN(4)) dut_c4 (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
      .hazard1(hazard1_b), .hazard2(hazard2_b),
      .issue_en(issue_en), .issue_reg(issue_reg),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_any(busy_any_b), .wr_count(wr_count4)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           sel_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;

   logic [W-1:0] m_exp;
   logic [W-1:0] m_got;
   int           m_sel;
   string        m_name;

   function automatic logic [W-1:0] dut_value(input int sel);
      case (sel)
         S_RD1:   return rd_data1;
         S_RD2:   return rd_data2;
         S_HZ1:   return {31'd0, hazard1};
         S_HZ2:   return {31'd0, hazard2};
         S_BUSY:  return {31'd0, busy_any};
         S_CNT:   return {16'd0, wr_count};
         S_CNT4:  return {28'd0, wr_count4};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_val(input int sel, input logic [W-1:0] v, input string nm);
      exp_q.push_back(v);
      sel_q.push_back(sel);
      name_q.push_back(nm);
   endtask

   // Monitor: every negedge, compare all expectations queued for this cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         m_exp  = exp_q.pop_front();
         m_sel  = sel_q.pop_front();
         m_name = name_q.pop_front();
         m_got  = dut_value(m_sel);
         n_checks++;
         if (m_got === m_exp) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", m_name, m_got, m_exp, $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_en  = 1'b0;
      issue_reg = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic do_issue(input logic [4:0] r);
      issue_en  = 1'b1;
      issue_reg = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state: image holds register index; nothing busy; counters zero.
      reset = 1'b1;
      idle_inputs();
      rd_addr1 = 5'd7;
      rd_addr2 = 5'd0;
      expect_val(S_RD1,  32'd7, "reset_rd1_r7");
      expect_val(S_RD2,  32'd0, "reset_rd2_r0");
      expect_val(S_HZ1,  32'd0, "reset_hazard1");
      expect_val(S_HZ2,  32'd0, "reset_hazard2");
      expect_val(S_BUSY, 32'd0, "reset_busy_any");
      expect_val(S_CNT,  32'd0, "reset_wr_count");
      expect_val(S_CNT4, 32'd0, "reset_wr_count4");
      next_cycle();

      // Write r5 with a same-cycle read: bypass supplies the data.
      reset = 1'b0;
      do_write(5'd5, 32'hDEAD_BEEF);
      rd_addr1 = 5'd5;
      rd_addr2 = 5'd6;
      expect_val(S_RD1, 32'hDEAD_BEEF, "bypass_r5");
      expect_val(S_RD2, 32'd6,         "image_r6");
      expect_val(S_CNT, 32'd0,         "count_before_edge");
      next_cycle();
      idle_inputs();
      expect_val(S_RD1,  32'hDEAD_BEEF, "mem_r5");
      expect_val(S_CNT,  32'd1,         "count_after_r5");
      expect_val(S_CNT4, 32'd1,         "count4_after_r5");
      next_cycle();

      // Write to r0 is discarded, not bypassed and not counted.
      do_write(5'd0, 32'h0000_1234);
      rd_addr1 = 5'd0;
      rd_addr2 = 5'd0;
      expect_val(S_RD1, 32'd0, "r0_no_bypass1");
      expect_val(S_RD2, 32'd0, "r0_no_bypass2");
      next_cycle();
      idle_inputs();
      expect_val(S_RD1, 32'd0, "r0_still_zero");
      expect_val(S_CNT, 32'd1, "r0_not_counted");
      next_cycle();

      // Issue r3: not visible until the next cycle.
      do_issue(5'd3);
      rd_addr1 = 5'd3;
      expect_val(S_HZ1,  32'd0, "issue_same_cycle_hz1");
      expect_val(S_BUSY, 32'd0, "issue_same_cycle_busy");
      expect_val(S_RD1,  32'd3, "image_r3");
      next_cycle();
      idle_inputs();
      rd_addr2 = 5'd3;
      expect_val(S_HZ1,  32'd1, "r3_hazard1");
      expect_val(S_HZ2,  32'd1, "r3_hazard2");
      expect_val(S_BUSY, 32'd1, "r3_busy_any");
      next_cycle();

      // Write-back r3 resolves the hazard in the same cycle.
      do_write(5'd3, 32'h55);
      expect_val(S_HZ1,  32'd0,  "wb_r3_hazard1");
      expect_val(S_HZ2,  32'd0,  "wb_r3_hazard2");
      expect_val(S_RD1,  32'h55, "wb_r3_bypass");
      expect_val(S_BUSY, 32'd1,  "wb_r3_busy_pre_edge");
      next_cycle();
      idle_inputs();
      expect_val(S_BUSY, 32'd0,  "r3_retired");
      expect_val(S_RD1,  32'h55, "mem_r3");
      expect_val(S_CNT,  32'd2,  "count_after_r3");
      next_cycle();

      // Issue and write-back r9 together: data lands, register stays busy.
      do_issue(5'd9);
      do_write(5'd9, 32'hAA);
      rd_addr1 = 5'd9;
      rd_addr2 = 5'd1;
      expect_val(S_RD1, 32'hAA, "r9_bypass");
      expect_val(S_HZ1, 32'd0,  "r9_hz_same_cycle");
      next_cycle();
      idle_inputs();
      expect_val(S_HZ1,  32'd1,  "r9_issue_wins");
      expect_val(S_RD1,  32'hAA, "mem_r9");
      expect_val(S_BUSY, 32'd1,  "r9_busy_any");
      expect_val(S_CNT,  32'd3,  "count_after_r9");
      next_cycle();
      do_write(5'd9, 32'hBB);
      expect_val(S_HZ1, 32'd0,  "r9_wb2_hazard");
      expect_val(S_RD1, 32'hBB, "r9_wb2_bypass");
      next_cycle();
      idle_inputs();
      expect_val(S_HZ1,  32'd0,  "r9_cleared");
      expect_val(S_BUSY, 32'd0,  "r9_busy_clear");
      expect_val(S_RD1,  32'hBB, "mem_r9_b");
      expect_val(S_CNT,  32'd4,  "count_after_r9b");
      next_cycle();

      // Issue to r0 is ignored.
      do_issue(5'd0);
      rd_addr1 = 5'd31;
      expect_val(S_RD1, 32'd31, "image_r31");
      next_cycle();
      idle_inputs();
      rd_addr1 = 5'd0;
      expect_val(S_BUSY, 32'd0, "issue_r0_ignored");
      expect_val(S_HZ1,  32'd0, "issue_r0_no_hazard");
      next_cycle();

      // Twelve more counted writes: 16 total, so the 4-bit counter wraps.
      for (int i = 0; i < 12; i++) begin
         do_write(5'(10 + i), 32'h100 + 32'(i));
         rd_addr2 = 5'(10 + i);
         expect_val(S_RD2, 32'h100 + 32'(i), "loop_bypass_rd2");
         next_cycle();
      end
      idle_inputs();
      rd_addr1 = 5'd10;
      rd_addr2 = 5'd21;
      expect_val(S_RD1,  32'h100, "mem_r10");
      expect_val(S_RD2,  32'h10B, "mem_r21");
      expect_val(S_CNT,  32'd16,  "count_16");
      expect_val(S_CNT4, 32'd0,   "count4_wrapped");
      next_cycle();

      // Issue r4 and r6, then assert reset between edges.
      do_issue(5'd4);
      next_cycle();
      do_issue(5'd6);
      next_cycle();
      idle_inputs();
      rd_addr1 = 5'd4;
      rd_addr2 = 5'd6;
      expect_val(S_HZ1,  32'd1, "r4_hazard");
      expect_val(S_HZ2,  32'd1, "r6_hazard");
      expect_val(S_BUSY, 32'd1, "r4_r6_busy");
      next_cycle();
      reset    = 1'b1;
      rd_addr2 = 5'd5;
      expect_val(S_HZ1,  32'd0, "async_reset_hz1");
      expect_val(S_HZ2,  32'd0, "async_reset_hz2");
      expect_val(S_BUSY, 32'd0, "async_reset_busy");
      expect_val(S_CNT,  32'd0, "async_reset_count");
      expect_val(S_RD1,  32'd4, "async_reset_r4");
      expect_val(S_RD2,  32'd5, "async_reset_r5_image");
      next_cycle();

      // Write coincident with the first edge after reset release commits.
      reset = 1'b0;
      do_write(5'd7, 32'h77);
      next_cycle();
      idle_inputs();
      rd_addr1 = 5'd7;
      expect_val(S_RD1,  32'h77, "first_edge_write");
      expect_val(S_CNT,  32'd1,  "first_edge_count");
      expect_val(S_CNT4, 32'd1,  "first_edge_count4");
      next_cycle();

      // Drain: the monitor must have retired every expectation.
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
      end

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the pipeline's 2-read/1-write integer register file.
- Adds a per-register scoreboard (busy bits), same-cycle write-to-read bypass, a selectable reset image and write-port statistics.
- Sits between ID and WB of the pipelined CPU: ID reads operands and issues destinations; WB writes results and retires them.

Parameters:
- WORD_LEN, 32, data width in bits.
- ADDR_LEN, 5, register address width; DEPTH = 2**ADDR_LEN registers.
- RESET_MODE, 1, reset image: 0 = all registers zero; 1 = register i holds i, zero-extended/truncated to WORD_LEN.
- CNT_LEN, 16, width of the write counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr1  in  ADDR_LEN  read port 1 address.
- rd_addr2  in  ADDR_LEN  read port 2 address.
- rd_data1  out  WORD_LEN  read port 1 data (combinational).
- rd_data2  out  WORD_LEN  read port 2 data (combinational).
- hazard1  out  1  operand 1 has a pending writer.
- hazard2  out  1  operand 2 has a pending writer.
- issue_en  in  1  mark issue_reg busy.
- issue_reg  in  ADDR_LEN  destination being issued.
- wr_en  in  1  write-back enable.
- wr_addr  in  ADDR_LEN  write-back address.
- wr_data  in  WORD_LEN  write-back data.
- busy_any  out  1  OR of all busy bits.
- wr_count  out  CNT_LEN  count of committed writes.

Behaviour:
- Reset (async, immediate):
  - Register array loads the RESET_MODE image; register 0 is always 0.
  - All busy bits clear; wr_count = 0.
  - Outputs settle combinationally from the reset state: hazard1/2 = 0, busy_any = 0; rd_data reflects the image.
- Write:
  - On posedge with wr_en = 1 and wr_addr != 0, mem[wr_addr] <= wr_data and wr_count increments.
  - wr_count wraps modulo 2**CNT_LEN.
  - A write to register 0 is discarded and is not counted.
- Read:
  - rd_dataN = 0 if rd_addrN == 0.
  - Otherwise rd_dataN = wr_data if wr_en && wr_addr == rd_addrN (bypass; zero added latency).
  - Otherwise rd_dataN = mem[rd_addrN].
- Scoreboard, per register r != 0, next busy[r]:
  - issue_en && issue_reg == r: 1. Issue wins over a simultaneous write-back to the same r, because a new writer is pending.
  - Else wr_en && wr_addr == r: 0.
  - Else: unchanged.
  - busy[0] is constant 0; issue_reg == 0 is ignored.
  - Issue to an already-busy register keeps it busy; no error, single-bit scoreboard.
  - Write-back to a non-busy register still writes data and counts.
- Hazard:
  - hazardN = busy[rd_addrN] && !(wr_en && wr_addr == rd_addrN).
  - A write-back in the same cycle resolves the hazard, and the bypass supplies the data.
  - The issue in the current cycle does not affect hazardN until the next cycle.
- busy_any = |busy, combinational from registered state.
- Reset asserted mid-operation: all pending busy bits and in-flight writes are lost. A write coincident with reset deassertion's first edge is performed normally.
- Latency:
  - Reads are 0-cycle (combinational).
  - Writes are visible via memory from the cycle after the edge, and via bypass in the same cycle.
  - Busy bits update at the edge.

Test Plan:
- Reset with RESET_MODE=1, WORD_LEN=32 -> rd_addr1=7 gives 7, rd_addr2=0 gives 0; hazards 0; busy_any 0; wr_count 0.
- Write 0xDEADBEEF to r5 while rd_addr1=5 in the same cycle -> rd_data1=0xDEADBEEF before the edge (bypass); after the edge rd_data1 still 0xDEADBEEF with wr_en=0; wr_count=1.
- Write 0x1234 to r0 -> rd_data of r0 stays 0; wr_count unchanged.
- Issue r3, next cycle rd_addr1=3 -> hazard1=1, busy_any=1. Write-back r3=0x55 with rd_addr1=3 -> hazard1=0 that cycle and rd_data1=0x55; next cycle busy_any=0.
- Same cycle issue r9 and write-back r9=0xAA -> mem[9]=0xAA, busy[9] stays 1 (hazard on read of r9 next cycle); a later write-back clears it.
- Issue r4, r6, then assert reset asynchronously mid-cycle -> hazards and busy_any drop immediately, wr_count=0. Wrap check: CNT_LEN=4, 16 writes -> wr_count=0.
